// File: rtl/sram_write_buffer.sv
// Posted-write buffer between the data cache controller and the SRAM controller.
// Define WBUF_FORWARD_EN to forward loads that hit a queued store and let read misses bypass the queue.
module sram_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  address,
  input  logic [31:0]                  wdata,
  input  logic                         read,
  input  logic                         write,
  output logic [31:0]                  rdata,
  output logic                         ready,
  output logic [31:0]                  sram_address,
  output logic [31:0]                  sram_wdata,
  output logic                         sram_read,
  output logic                         sram_write,
  input  logic [31:0]                  sram_rdata,
  input  logic                         sram_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TAG_W = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_d;

  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  logic        full;
  logic        enq, deq;
  logic        rd_req;
  logic        rd_issue;
  logic        fwd_hit;
  logic [31:0] hit_data;

  logic        ready_d;
  logic [31:0] rdata_d;
  logic [31:0] sram_address_d;
  logic [31:0] sram_wdata_d;
  logic        sram_read_d;
  logic        sram_write_d;

  // The byte offset never takes part in matching or SRAM addressing.
  logic unused_addr;
  assign unused_addr = ^address[1:0];

  // Requests are only sampled outside the ready pulse; write wins over read.
  assign full   = (count == CNT_W'(DEPTH));
  assign enq    = write & ~ready & ~full;
  assign rd_req = read & ~write & ~ready;
  assign deq    = (state == DRAIN) & sram_ready;

`ifdef WBUF_FORWARD_EN
  logic             hit;
  logic [PTR_W-1:0] idx;

  // Scan oldest to newest so the newest matching store wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (mem_tag[idx] == address[31:2])) begin
        hit      = 1'b1;
        hit_data = mem_data[idx];
      end
    end
  end

  assign fwd_hit  = rd_req & hit;
  assign rd_issue = rd_req & ~hit;
`else
  // Loads are ordered behind every buffered store.
  assign fwd_hit  = 1'b0;
  assign hit_data = '0;
  assign rd_issue = rd_req & (count == '0);
`endif

  // Entry storage; validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_tag[wr_ptr]  <= address[31:2];
      mem_data[wr_ptr] <= wdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // SRAM-side state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state: a pending read takes IDLE first, an in-flight drain always completes.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (rd_issue)            state_d = READ;
        else if (count != '0)    state_d = DRAIN;
      end
      DRAIN:   if (sram_ready) state_d = IDLE;
      READ:    if (sram_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    ready_d        = 1'b0;
    rdata_d        = rdata;
    sram_address_d = sram_address;
    sram_wdata_d   = sram_wdata;
    sram_read_d    = sram_read;
    sram_write_d   = sram_write;
    if (enq) ready_d = 1'b1;
    if (fwd_hit) begin
      ready_d = 1'b1;
      rdata_d = hit_data;
    end
    case (state)
      IDLE: begin
        if (rd_issue) begin
          sram_read_d    = 1'b1;
          sram_address_d = {address[31:2], 2'b00};
        end else if (count != '0) begin
          sram_write_d   = 1'b1;
          sram_address_d = {mem_tag[rd_ptr], 2'b00};
          sram_wdata_d   = mem_data[rd_ptr];
        end
      end
      DRAIN: begin
        if (sram_ready) sram_write_d = 1'b0;
      end
      READ: begin
        if (sram_ready) begin
          sram_read_d = 1'b0;
          rdata_d     = sram_rdata;
          ready_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready        <= 1'b0;
      rdata        <= '0;
      sram_address <= '0;
      sram_wdata   <= '0;
      sram_read    <= 1'b0;
      sram_write   <= 1'b0;
    end else begin
      ready        <= ready_d;
      rdata        <= rdata_d;
      sram_address <= sram_address_d;
      sram_wdata   <= sram_wdata_d;
      sram_read    <= sram_read_d;
      sram_write   <= sram_write_d;
    end
  end

endmodule

// File: doc/sram_write_buffer.md
# sram_write_buffer

Posted-write buffer between the data cache controller and the SRAM controller in the MEM stage. Stores are acknowledged as soon as they are queued and drained to SRAM in the background, so a store stalls the pipeline for one cycle instead of a full SRAM cycle. Loads are served from the buffer on an address match, or from SRAM otherwise. The block is transparent to the cache controller: it presents the same read/write/ready handshake the SRAM controller does.

## Interface
- DEPTH, 4: number of buffered writes; a power of two, at least 2.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- address  in  32  upstream byte address; bits [31:2] select the word
- wdata  in  32  upstream store data
- read  in  1  upstream load request, level, held until ready
- write  in  1  upstream store request, level, held until ready
- rdata  out  32  load data, valid while ready is high
- ready  out  1  one-cycle completion pulse for the current request
- sram_address  out  32  SRAM controller address
- sram_wdata  out  32  SRAM controller write data
- sram_read  out  1  SRAM read request, held until sram_ready
- sram_write  out  1  SRAM write request, held until sram_ready
- sram_rdata  in  32  SRAM read data, valid with sram_ready
- sram_ready  in  1  SRAM controller completion pulse
- count  out  $clog2(DEPTH+1)  current number of buffered entries

## Operation
- Circular FIFO: DEPTH entries of {addr[31:2], data}, with write pointer, read pointer and count.
- Upstream requests:
  - read and write are never high together; if they are, write wins.
  - A request is sampled only when ready is low. A request still high during a ready cycle is ignored, because the requester drops it after ready.
- Write accept:
  - Condition: write=1, not full, ready=0.
  - Enqueues at the clock edge. ready=1 in the next cycle.
- Write when full:
  - No enqueue until the next drain completes.
  - A slot freed by sram_ready at edge N is used at edge N+1.
- Read hit (forwarding enabled): address[31:2] matches a valid entry.
  - The newest matching entry's data is registered to rdata. ready=1 next cycle.
  - No SRAM access.
- Read miss: served through the SRAM read path described below.
- SRAM-side FSM:
  - IDLE
    - A read miss is pending and allowed: go to READ and drive sram_read=1 with sram_address={address[31:2],2'b00}.
    - Otherwise, if count>0: go to DRAIN and drive sram_write=1 with the head entry's address and data.
  - DRAIN
    - Hold all SRAM outputs until sram_ready=1.
    - On sram_ready: dequeue the head, decrement count, return to IDLE.
  - READ
    - Hold until sram_ready=1.
    - On sram_ready: capture sram_rdata into rdata, go to RESP.
  - RESP
    - ready=1 for one cycle, then IDLE.
- Read-miss priority: a pending read miss takes priority over draining when the FSM is in IDLE. An in-flight drain is never aborted.
- Simultaneous events:
  - An enqueue and a dequeue on the same edge leave count unchanged.
  - Enqueue proceeds in any FSM state.
- Pointers wrap modulo DEPTH.
- count ranges over 0..DEPTH.
- Match logic ignores address bits [1:0].

## Timing
- Reset values:
  - ready=0, rdata=0, sram_read=0, sram_write=0, sram_address=0, sram_wdata=0, count=0.
  - Pointers are 0 and the FSM is in IDLE.
- Reset mid-operation: all buffered writes are discarded. The SRAM controller shares rst, so any in-flight access is abandoned too.
- Store latency: request seen at edge N, ready high in cycle N+1 (N is not full).
- Read-hit latency: same as a store.
- Read-miss latency, empty buffer:
  - sram_read rises after edge N.
  - rdata is captured at the edge where sram_ready=1 (edge M).
  - ready is high in cycle M+1.
- Read miss behind a drain in progress: the read is issued at the first IDLE after the drain completes.
- All outputs are registered. No combinational path exists from sram_ready to ready.

## Configuration
- WBUF_FORWARD_EN defined:
  - Address comparators are present and read hits are forwarded as described.
  - Read misses bypass queued writes.
- WBUF_FORWARD_EN undefined:
  - No comparators.
  - Every read waits until count=0 and the FSM is in IDLE, then goes to READ.
  - Loads are strictly ordered behind all buffered stores.

## Test plan
- Reset with wdata=32'hDEAD_BEEF and write=1 -> no enqueue while rst=1; all outputs 0 and count=0 throughout.
- Four stores to 0x100, 0x104, 0x108, 0x10C with sram_ready delayed 5 cycles -> each store gets ready one cycle after it is sampled. SRAM receives the four writes in order with matching data, and count returns to 0.
- DEPTH=4 buffer full, fifth store to 0x200 -> ready held low until the first drain's sram_ready. The store is accepted on the following edge and count reaches 4 again.
- With WBUF_FORWARD_EN: store 0x11111111 then 0x22222222 to 0x40, then load 0x42 -> rdata=0x22222222 one cycle after the load is sampled, with no sram_read.
- Without WBUF_FORWARD_EN: the same sequence -> sram_read is asserted only after both writes drain, and rdata equals the SRAM model value 0x22222222.
- Assert rst during DRAIN with count=3 -> next cycle: count=0, sram_write=0, FSM in IDLE, and no further SRAM writes.
